// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit/receive blocks.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_t;

  localparam logic SERIAL_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_baud_gen.sv
// Bit-period counter: counts 0..clksPerBit-1 and pulses bitTick on the terminal count.
module serial_baud_gen #(
  parameter int clksPerBit = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bitTick
);

  localparam int CW = (clksPerBit > 1) ? $clog2(clksPerBit) : 1;
  localparam logic [CW-1:0] TC = CW'(clksPerBit - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear || cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bitTick = (cnt == TC);

endmodule

// File: rtl/serial_fifo_tx.sv
// Serial transmitter draining a FIFO: start bit, LSB-first data, optional parity, stop bit.
module serial_fifo_tx
  import serial_pkg::*;
#(
  parameter int regWidth   = 8,
  parameter int clksPerBit = 16,
  parameter int parityEn   = 0,
  parameter int parityOdd  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                txEnable,
  input  logic                fifoEmpty,
  input  logic [regWidth-1:0] rData,
  output logic                rEnable,
  output logic                txOut,
  output logic                txBusy,
  output logic                txDone
);

  localparam int BW = $clog2(regWidth + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(regWidth - 1);

  txState_t            state;
  txState_t            state_nxt;
  logic [regWidth-1:0] shift;
  logic [BW-1:0]       bit_idx;
  logic                par_bit;
  logic                load;
  logic                bit_tick;
  logic                baud_clear;

  // Counter is held at 0 while idle so every bit period starts aligned to the state entry.
  assign baud_clear = (state_nxt != state) || (state == IDLE);

  serial_baud_gen #(
    .clksPerBit(clksPerBit)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear  (baud_clear),
    .bitTick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      par_bit <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        shift   <= rData;
        par_bit <= (^rData) ^ (parityOdd != 0);
      end else if (state == DATA && bit_tick) begin
        shift <= shift >> 1;
      end
      if (state == START && bit_tick) begin
        bit_idx <= '0;
      end else if (state == DATA && bit_tick) begin
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    rEnable   = 1'b0;
    txOut     = SERIAL_IDLE_LEVEL;
    txDone    = 1'b0;
    case (state)
      IDLE: begin
        // Gate on rst so the FIFO is never popped during a reset cycle.
        if (txEnable && !fifoEmpty && !rst) begin
          rEnable   = 1'b1;
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        txOut = 1'b0;
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        txOut = shift[0];
        if (bit_tick && bit_idx == LAST_BIT) begin
          state_nxt = (parityEn != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        txOut = par_bit;
        if (bit_tick) state_nxt = STOP;
      end
      STOP: begin
        txOut = SERIAL_IDLE_LEVEL;
        if (bit_tick) begin
          txDone    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign txBusy = (state != IDLE);

endmodule
